apb3_slot_bridge: RTL and testbench



---
 rtl/apb3_bridge_pkg.sv | 19 +
 rtl/apb3_slot_bridge_if.sv | 46 ++++
 rtl/apb3_timeout_ctr.sv | 33 +++
 rtl/apb3_slot_bridge.sv | 181 ++++++++++++++++++
 tb/tb_apb3_slot_bridge.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb3_bridge_pkg.sv
// Shared definitions for the APB3 slot bridge: FSM state encoding,
// error counter ceiling and the watchdog counter sizing helper.
package apb3_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

  // Bits needed to hold the values 0..cycles; never less than one bit.
  function automatic int unsigned ctr_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb3_slot_bridge_if.sv
// APB3 bundle seen by the bridge: the MSS master-side port plus the
// fanned-out fabric slave-side port with flattened per-slot return paths.
interface apb3_slot_bridge_if #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned SLOT_SHIFT = 8
);

  // MSS master side
  logic                            PSEL;
  logic                            PENABLE;
  logic                            PWRITE;
  logic [ADDR_WIDTH-1:0]           PADDR;
  logic [DATA_WIDTH-1:0]           PWDATA;
  logic [DATA_WIDTH-1:0]           PRDATA;
  logic                            PREADY;
  logic                            PSLVERR;

  // Fabric slave side
  logic [NUM_SLOTS-1:0]            PSELS;
  logic                            PENABLES;
  logic                            PWRITES;
  logic [SLOT_SHIFT-1:0]           PADDRS;
  logic [DATA_WIDTH-1:0]           PWDATAS;
  logic [NUM_SLOTS*DATA_WIDTH-1:0] PRDATAS;
  logic [NUM_SLOTS-1:0]            PREADYS;
  logic [NUM_SLOTS-1:0]            PSLVERRS;

  // View of the bridge: APB slave toward the MSS, master toward the slots.
  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR,
    output PSELS, PENABLES, PWRITES, PADDRS, PWDATAS,
    input  PRDATAS, PREADYS, PSLVERRS
  );

  // View of the surrounding system: MSS master plus the fabric slaves.
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR,
    input  PSELS, PENABLES, PWRITES, PADDRS, PWDATAS,
    output PRDATAS, PREADYS, PSLVERRS
  );

endinterface

// File: rtl/apb3_timeout_ctr.sv
// Access-phase watchdog. clear loads 1 so the first access cycle reads 1;
// enable counts further access cycles; expire flags the limit cycle.
// A TIMEOUT_CYCLES of 0 disables expiry entirely.
module apb3_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  import apb3_bridge_pkg::*;

  localparam int unsigned W     = ctr_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  // Count access cycles, holding at the limit so the value never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= W'(1);
    end else if (enable && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  assign expire = (TIMEOUT_CYCLES != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/apb3_slot_bridge.sv
// APB3 fabric bridge: registers each MSS transfer, decodes the slot field
// of PADDR and replays the transfer to one fabric slave, with a timeout
// watchdog, unmapped-slot errors, sticky error status and masked
// interrupt aggregation toward FABINT.
module apb3_slot_bridge #(
  parameter int unsigned         NUM_SLOTS      = 4,
  parameter int unsigned         DATA_WIDTH     = 32,
  parameter int unsigned         ADDR_WIDTH     = 20,
  parameter int unsigned         SLOT_SHIFT     = 8,
  parameter int unsigned         SLOT_BITS      = 4,
  parameter logic [NUM_SLOTS-1:0] SLOT_ENABLE   = '1,
  parameter logic [NUM_SLOTS-1:0] INT_MASK      = '1,
  parameter int unsigned         TIMEOUT_CYCLES = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb3_slot_bridge_if.slave    bus,
  input  logic [NUM_SLOTS-1:0] FABINTS,
  output logic                 FABINT,
  output logic [7:0]           ERR_COUNT,
  output logic [SLOT_BITS-1:0] ERR_SLOT,
  output logic                 ERR_TIMEOUT
);
  import apb3_bridge_pkg::*;

  state_t                state;
  logic [SLOT_BITS-1:0]  slot;
  logic [SLOT_BITS-1:0]  idx;
  logic [SLOT_BITS-1:0]  err_slot_src;
  logic                  mapped;
  logic                  slot_ready;
  logic                  slot_err;
  logic [DATA_WIDTH-1:0] slot_rdata;
  logic                  err_hit;
  logic                  err_tmo_hit;
  logic                  tmo_expire;
  logic                  unused_addr;

  // Slot index field of the incoming address; bits above it are don't-care.
  assign idx         = bus.PADDR[SLOT_SHIFT +: SLOT_BITS];
  assign unused_addr = ^bus.PADDR;

  // Decode whether the incoming slot is populated, and mux the return
  // path of the captured slot. Loop compares avoid out-of-range indexing
  // when the slot field can name more slots than exist.
  always_comb begin
    mapped     = 1'b0;
    slot_ready = 1'b0;
    slot_err   = 1'b0;
    slot_rdata = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if ((idx == SLOT_BITS'(k)) && SLOT_ENABLE[k]) begin
        mapped = 1'b1;
      end
      if (slot == SLOT_BITS'(k)) begin
        slot_ready = bus.PREADYS[k];
        slot_err   = bus.PSLVERRS[k];
        slot_rdata = bus.PRDATAS[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Identify an erroring transition into RESP this cycle and its cause.
  always_comb begin
    err_hit      = 1'b0;
    err_tmo_hit  = 1'b0;
    err_slot_src = idx;
    case (state)
      IDLE: begin
        err_hit = bus.PSEL && !bus.PENABLE && !mapped;
      end
      ACCESS: begin
        err_slot_src = slot;
        if (slot_ready) begin
          err_hit = slot_err;
        end else if (tmo_expire) begin
          err_hit     = 1'b1;
          err_tmo_hit = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  apb3_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (PCLK),
    .rst   (PRESET),
    .clear (state == SETUP),
    .enable(state == ACCESS),
    .expire(tmo_expire)
  );

  // Transfer FSM with registered master- and slave-side outputs. Response
  // signals toward the master are qualified by PSEL at the moment RESP is
  // entered, so an aborted master sees no PREADY.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state        <= IDLE;
      slot         <= '0;
      bus.PREADY   <= 1'b0;
      bus.PSLVERR  <= 1'b0;
      bus.PRDATA   <= '0;
      bus.PSELS    <= '0;
      bus.PENABLES <= 1'b0;
      bus.PWRITES  <= 1'b0;
      bus.PADDRS   <= '0;
      bus.PWDATAS  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.PSEL && !bus.PENABLE) begin
            slot        <= idx;
            bus.PWRITES <= bus.PWRITE;
            bus.PADDRS  <= bus.PADDR[SLOT_SHIFT-1:0];
            bus.PWDATAS <= bus.PWDATA;
            if (mapped) begin
              state     <= SETUP;
              bus.PSELS <= NUM_SLOTS'(1) << idx;
            end else begin
              state       <= RESP;
              bus.PREADY  <= 1'b1;
              bus.PSLVERR <= 1'b1;
            end
          end
        end
        SETUP: begin
          state        <= ACCESS;
          bus.PENABLES <= 1'b1;
        end
        ACCESS: begin
          if (slot_ready || tmo_expire) begin
            state        <= RESP;
            bus.PSELS    <= '0;
            bus.PENABLES <= 1'b0;
            bus.PREADY   <= bus.PSEL;
            bus.PSLVERR  <= bus.PSEL && err_hit;
            bus.PRDATA   <= (bus.PSEL && slot_ready && !slot_err && !bus.PWRITES)
                            ? slot_rdata : '0;
          end
        end
        RESP: begin
          state       <= IDLE;
          bus.PREADY  <= 1'b0;
          bus.PSLVERR <= 1'b0;
          bus.PRDATA  <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky error status, updated as an erroring transfer enters RESP.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ERR_COUNT   <= '0;
      ERR_SLOT    <= '0;
      ERR_TIMEOUT <= 1'b0;
    end else if (err_hit) begin
      if (ERR_COUNT != ERR_COUNT_MAX) begin
        ERR_COUNT <= ERR_COUNT + 8'd1;
      end
      ERR_SLOT    <= err_slot_src;
      ERR_TIMEOUT <= err_tmo_hit;
    end
  end

  // Masked interrupt aggregation, one register stage, independent of FSM.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      FABINT <= 1'b0;
    end else begin
      FABINT <= |(FABINTS & INT_MASK);
    end
  end

endmodule

// File: tb/tb_apb3_slot_bridge.sv
// Bench for apb3_slot_bridge: directed scenarios plus randomized transfers
// checked against a transaction-level model of latency, response and
// error status.
module tb_apb3_slot_bridge;
  localparam int unsigned NS  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 20;
  localparam int unsigned SS  = 8;
  localparam int unsigned SB  = 4;
  localparam int          TMO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic [NS-1:0] FABINTS;
  logic          FABINT;
  logic [7:0]    ERR_COUNT;
  logic [SB-1:0] ERR_SLOT;
  logic          ERR_TIMEOUT;

  always #5 PCLK = ~PCLK;

  apb3_slot_bridge_if #(
    .NUM_SLOTS(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLOT_SHIFT(SS)
  ) bus ();

  apb3_slot_bridge #(
    .NUM_SLOTS(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLOT_SHIFT(SS),
    .SLOT_BITS(SB), .SLOT_ENABLE(4'b1111), .INT_MASK(4'b0111),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus), .FABINTS(FABINTS),
    .FABINT(FABINT), .ERR_COUNT(ERR_COUNT), .ERR_SLOT(ERR_SLOT),
    .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] sdata [NS];

  // Observations from the last transfer
  int            obs_lat;
  logic          obs_err;
  logic [DW-1:0] obs_rd, obs_post_rd, obs_wd1;
  logic          obs_post_ready, obs_en1, obs_en2, obs_wr1, obs_any_sel;
  logic [NS-1:0] obs_sel1, obs_resp_sel;
  logic [SS-1:0] obs_addr1;

  // Model expectations
  int            exp_lat;
  logic          exp_err, exp_tmo, exp_mapped;
  logic [DW-1:0] exp_rd;
  logic [NS-1:0] exp_sel;
  int            m_cnt = 0;
  int            m_slot = 0;
  logic          m_tmo = 1'b0;

  function automatic logic [127:0] all_outs();
    return 128'({bus.PREADY, bus.PSLVERR, bus.PRDATA, bus.PSELS, bus.PENABLES,
                 bus.PWRITES, bus.PADDRS, bus.PWDATAS, FABINT, ERR_COUNT,
                 ERR_SLOT, ERR_TIMEOUT});
  endfunction

  // Transaction-level reference: what the master should observe.
  task automatic model(input logic [AW-1:0] a, input logic w, input int waits,
                       input logic serr);
    int slot;
    slot       = int'(a[SS +: SB]);
    exp_mapped = (slot < NS);
    exp_tmo    = exp_mapped && (waits >= TMO);
    exp_err    = !exp_mapped || exp_tmo || serr;
    if (!exp_mapped)  exp_lat = 1;
    else if (exp_tmo) exp_lat = TMO + 2;
    else              exp_lat = waits + 3;
    exp_rd = '0;
    if (!w && !exp_err) exp_rd = sdata[slot];
    exp_sel = '0;
    if (exp_mapped) exp_sel[slot] = 1'b1;
    if (exp_err) begin
      if (m_cnt < 255) m_cnt++;
      m_slot = slot;
      m_tmo  = exp_tmo;
    end
  endtask

  task automatic fill_sdata();
    for (int k = 0; k < NS; k++) sdata[k] = $urandom;
  endtask

  // Master plus slave behaviour for one transfer; records observations.
  task automatic xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                      input int waits, input logic serr);
    int cyc;
    int acc;
    bit done;
    @(negedge PCLK);
    for (int k = 0; k < NS; k++) bus.PRDATAS[k*DW +: DW] = sdata[k];
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = a; bus.PWRITE = w; bus.PWDATA = wd;
    bus.PREADYS = '0; bus.PSLVERRS = '0;
    cyc = 0; acc = 0; done = 1'b0;
    obs_lat = -1; obs_err = 1'b0; obs_rd = '0; obs_any_sel = 1'b0; obs_resp_sel = '1;
    while (!done && cyc < 40) begin
      @(negedge PCLK);
      cyc++;
      bus.PENABLE = 1'b1;
      if (bus.PSELS != '0) obs_any_sel = 1'b1;
      if (cyc == 1) begin
        obs_sel1 = bus.PSELS; obs_en1 = bus.PENABLES; obs_addr1 = bus.PADDRS;
        obs_wd1 = bus.PWDATAS; obs_wr1 = bus.PWRITES;
      end
      if (cyc == 2) obs_en2 = bus.PENABLES;
      if (bus.PREADY) begin
        done = 1'b1; obs_lat = cyc; obs_err = bus.PSLVERR; obs_rd = bus.PRDATA;
        obs_resp_sel = bus.PSELS;
      end else begin
        if (bus.PENABLES && bus.PSELS != '0) acc++;
        bus.PREADYS  = NS'($urandom) & ~bus.PSELS;
        bus.PSLVERRS = (NS'($urandom) & ~bus.PSELS) | (serr ? bus.PSELS : '0);
        if (bus.PENABLES && acc > waits) bus.PREADYS = bus.PREADYS | bus.PSELS;
      end
    end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PREADYS = '0; bus.PSLVERRS = '0;
    @(negedge PCLK);
    obs_post_rd = bus.PRDATA; obs_post_ready = bus.PREADY;
  endtask

  task automatic test_reset();
    FABINTS = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0; bus.PRDATAS = '0; bus.PREADYS = '0; bus.PSLVERRS = '0;
    @(negedge PCLK);
    @(negedge PCLK);
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++; $display("FAIL reset_state: got %h expected 0", all_outs());
    end
    PRESET = 1'b0;
  endtask

  task automatic test_zero_wait();
    fill_sdata();
    model(20'h00204, 1'b1, 0, 1'b0);
    xfer(20'h00204, 1'b1, 32'hDEADBEEF, 0, 1'b0);
    vectors++; if (obs_sel1 !== 4'b0100) begin miscompares++; $display("FAIL zw_psels: got %b expected 0100", obs_sel1); end
    vectors++; if (obs_addr1 !== 8'h04) begin miscompares++; $display("FAIL zw_paddrs: got %h expected 04", obs_addr1); end
    vectors++; if (obs_wd1 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL zw_pwdatas: got %h expected deadbeef", obs_wd1); end
    vectors++; if ({obs_wr1, obs_en1, obs_en2} !== 3'b101) begin miscompares++; $display("FAIL zw_wr_en: got %b expected 101", {obs_wr1, obs_en1, obs_en2}); end
    vectors++; if (obs_lat !== exp_lat || exp_lat != 3) begin miscompares++; $display("FAIL zw_latency: got %0d expected 3", obs_lat); end
    vectors++; if (obs_err !== 1'b0) begin miscompares++; $display("FAIL zw_pslverr: got %b expected 0", obs_err); end
  endtask

  task automatic test_read_wait();
    fill_sdata();
    sdata[1] = 32'h12345678;
    model(20'h00110, 1'b0, 2, 1'b0);
    xfer(20'h00110, 1'b0, '0, 2, 1'b0);
    vectors++; if (obs_lat !== 5) begin miscompares++; $display("FAIL rd_latency: got %0d expected 5", obs_lat); end
    vectors++; if (obs_rd !== 32'h12345678) begin miscompares++; $display("FAIL rd_data: got %h expected 12345678", obs_rd); end
    vectors++; if ({obs_post_rd, obs_post_ready} !== '0) begin miscompares++; $display("FAIL rd_after_resp: got %h/%b expected 0/0", obs_post_rd, obs_post_ready); end
    vectors++; if (obs_err !== 1'b0) begin miscompares++; $display("FAIL rd_pslverr: got %b expected 0", obs_err); end
  endtask

  task automatic test_unmapped();
    fill_sdata();
    model(20'h00500, 1'b0, 0, 1'b0);
    xfer(20'h00500, 1'b0, '0, 0, 1'b0);
    vectors++; if (obs_any_sel !== 1'b0) begin miscompares++; $display("FAIL um_psels: got %b expected 0", obs_any_sel); end
    vectors++; if (obs_lat !== 1 || obs_err !== 1'b1) begin miscompares++; $display("FAIL um_resp: got lat %0d err %b expected 1 1", obs_lat, obs_err); end
    vectors++; if ({ERR_COUNT, ERR_SLOT, ERR_TIMEOUT} !== {8'd1, 4'd5, 1'b0}) begin
      miscompares++; $display("FAIL um_status: got %0d/%0d/%b expected 1/5/0", ERR_COUNT, ERR_SLOT, ERR_TIMEOUT); end
  endtask

  task automatic test_timeout();
    fill_sdata();
    model(20'h00300, 1'b0, 100, 1'b0);
    xfer(20'h00300, 1'b0, '0, 100, 1'b0);
    vectors++; if (obs_lat !== 18 || obs_err !== 1'b1) begin miscompares++; $display("FAIL to_resp: got lat %0d err %b expected 18 1", obs_lat, obs_err); end
    vectors++; if (obs_resp_sel !== '0) begin miscompares++; $display("FAIL to_psels: got %b expected 0000", obs_resp_sel); end
    vectors++; if ({ERR_COUNT, ERR_SLOT, ERR_TIMEOUT} !== {8'd2, 4'd3, 1'b1}) begin
      miscompares++; $display("FAIL to_status: got %0d/%0d/%b expected 2/3/1", ERR_COUNT, ERR_SLOT, ERR_TIMEOUT); end
    fill_sdata();
    model(20'h00300, 1'b0, 15, 1'b0);
    xfer(20'h00300, 1'b0, '0, 15, 1'b0);
    vectors++; if (obs_lat !== 18 || obs_err !== 1'b0) begin miscompares++; $display("FAIL to_edge_ready: got lat %0d err %b expected 18 0", obs_lat, obs_err); end
    vectors++; if (obs_rd !== exp_rd) begin miscompares++; $display("FAIL to_edge_data: got %h expected %h", obs_rd, exp_rd); end
    vectors++; if (ERR_COUNT !== 8'd2) begin miscompares++; $display("FAIL to_edge_count: got %0d expected 2", ERR_COUNT); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge PCLK);
    FABINTS = 4'b0001;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = 20'h00110; bus.PWRITE = 1'b1;
    bus.PWDATA = 32'hA5A55A5A; bus.PREADYS = '0; bus.PSLVERRS = '0;
    @(negedge PCLK); bus.PENABLE = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    vectors++; if ({bus.PSELS, bus.PENABLES} !== 5'b00101) begin
      miscompares++; $display("FAIL mid_access_pre: got %b expected 00101", {bus.PSELS, bus.PENABLES}); end
    #2 PRESET = 1'b1;
    #1;
    vectors++; if (all_outs() !== '0) begin miscompares++; $display("FAIL mid_access_reset: got %h expected 0", all_outs()); end
    @(negedge PCLK);
    PRESET = 1'b0; FABINTS = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    m_cnt = 0; m_slot = 0; m_tmo = 1'b0;
    fill_sdata();
    model(20'h00110, 1'b0, 1, 1'b0);
    xfer(20'h00110, 1'b0, '0, 1, 1'b0);
    vectors++; if (obs_lat !== exp_lat || obs_rd !== exp_rd || obs_err !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_xfer: got %0d/%h/%b expected %0d/%h/0", obs_lat, obs_rd, obs_err, exp_lat, exp_rd); end
    vectors++; if (ERR_COUNT !== 8'd0) begin miscompares++; $display("FAIL post_reset_count: got %0d expected 0", ERR_COUNT); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic          w, serr;
    int            waits;
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom);
      a[SS +: SB] = SB'($urandom_range(0, 5));
      w = 1'($urandom);
      serr = ($urandom_range(0, 3) == 0);
      waits = ($urandom_range(0, 7) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 4);
      fill_sdata();
      model(a, w, waits, serr);
      xfer(a, w, DW'($urandom), waits, serr);
      vectors++; if (obs_lat !== exp_lat || obs_err !== exp_err) begin
        miscompares++; $display("FAIL rnd_resp[%0d]: got lat %0d err %b expected %0d %b", n, obs_lat, obs_err, exp_lat, exp_err); end
      vectors++; if (obs_rd !== exp_rd || obs_post_rd !== '0) begin
        miscompares++; $display("FAIL rnd_data[%0d]: got %h/%h expected %h/0", n, obs_rd, obs_post_rd, exp_rd); end
      vectors++; if (obs_sel1 !== exp_sel) begin
        miscompares++; $display("FAIL rnd_psels[%0d]: got %b expected %b", n, obs_sel1, exp_sel); end
      vectors++; if ({ERR_COUNT, ERR_SLOT, ERR_TIMEOUT} !== {8'(m_cnt), SB'(m_slot), m_tmo}) begin
        miscompares++; $display("FAIL rnd_status[%0d]: got %0d/%0d/%b expected %0d/%0d/%b", n, ERR_COUNT, ERR_SLOT, ERR_TIMEOUT, m_cnt, m_slot, m_tmo); end
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      fill_sdata();
      model(20'h00200, 1'b0, 0, 1'b1);
      xfer(20'h00200, 1'b0, '0, 0, 1'b1);
    end
    vectors++; if (ERR_COUNT !== 8'd255) begin miscompares++; $display("FAIL sat_count: got %0d expected 255", ERR_COUNT); end
    vectors++; if ({ERR_SLOT, ERR_TIMEOUT} !== {4'd2, 1'b0}) begin
      miscompares++; $display("FAIL sat_slot: got %0d/%b expected 2/0", ERR_SLOT, ERR_TIMEOUT); end
    vectors++; if (obs_err !== 1'b1 || obs_rd !== '0) begin
      miscompares++; $display("FAIL sat_resp: got err %b data %h expected 1 0", obs_err, obs_rd); end
  endtask

  task automatic test_fabint();
    @(negedge PCLK); FABINTS = 4'b1000;
    @(negedge PCLK);
    @(negedge PCLK);
    vectors++; if (FABINT !== 1'b0) begin miscompares++; $display("FAIL fabint_masked: got %b expected 0", FABINT); end
    FABINTS = 4'b0010;
    #1;
    vectors++; if (FABINT !== 1'b0) begin miscompares++; $display("FAIL fabint_latency: got %b expected 0", FABINT); end
    @(negedge PCLK);
    vectors++; if (FABINT !== 1'b1) begin miscompares++; $display("FAIL fabint_pass: got %b expected 1", FABINT); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_read_wait();
    test_unmapped();
    test_timeout();
    test_reset_mid_access();
    test_random();
    test_saturation();
    test_fabint();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
